// File: rtl/cursor_tracker.sv
// Joystick-to-cursor integrator: registered deflections move a clamped VGA cursor
// once per update tick, with a deadzone and two speed tiers per axis.
module cursor_tracker #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned DEADZONE    = 48,
  parameter int unsigned FAST_THRESH = 96,
  parameter int unsigned SLOW_STEP   = 1,
  parameter int unsigned FAST_STEP   = 4,
  parameter int unsigned TICK_DIV    = 416667
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         positionX,
  input  logic [7:0]         positionY,
  input  logic               enable,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic               moved
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam int unsigned WideW = COORD_W + 1;

  localparam logic [CntW-1:0]    CntMax = CntW'(TICK_DIV - 1);
  localparam logic [COORD_W:0]   XMax   = WideW'(H_RES - 1);
  localparam logic [COORD_W:0]   YMax   = WideW'(V_RES - 1);
  localparam logic [COORD_W-1:0] XRst   = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] YRst   = COORD_W'(V_RES / 2);
  localparam logic [8:0]         DzLim  = 9'(DEADZONE);
  localparam logic [8:0]         FastLim = 9'(FAST_THRESH);
  localparam logic [COORD_W:0]   SlowW  = WideW'(SLOW_STEP);
  localparam logic [COORD_W:0]   FastW  = WideW'(FAST_STEP);

  logic [7:0]         sx, sy;
  logic [CntW-1:0]    tick_cnt;
  logic               tick;
  logic [COORD_W:0]   step_x, step_y;
  logic [COORD_W-1:0] next_x, next_y;

  // Magnitude kept 9 bits wide so -128 maps to 128 and lands in the fast tier.
  function automatic logic [COORD_W:0] step_of(input logic [7:0] s);
    logic [8:0]       mag;
    logic [COORD_W:0] step;
    mag = {1'b0, (s[7] ? (8'd0 - s) : s)};
    if (mag <= DzLim) begin
      step = '0;
    end else if (mag >= FastLim) begin
      step = FastW;
    end else begin
      step = SlowW;
    end
    return step;
  endfunction

  // Saturating move in one extra bit of headroom so neither end can wrap.
  function automatic logic [COORD_W-1:0] move_axis(input logic [COORD_W-1:0] cur,
                                                   input logic [COORD_W:0]   step,
                                                   input logic               add,
                                                   input logic [COORD_W:0]   max_v);
    logic [COORD_W:0] wide, sum, res;
    wide = {1'b0, cur};
    sum  = wide + step;
    if (add) begin
      res = (sum > max_v) ? max_v : sum;
    end else begin
      res = (wide < step) ? '0 : (wide - step);
    end
    return COORD_W'(res);
  endfunction

  always_comb begin
    tick   = (tick_cnt == CntMax);
    step_x = step_of(sx);
    step_y = step_of(sy);
    // X grows for positive deflection; Y grows for negative (screen rows run downward).
    next_x = move_axis(vga_x, step_x, ~sx[7], XMax);
    next_y = move_axis(vga_y, step_y, sy[7], YMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx       <= '0;
      sy       <= '0;
      tick_cnt <= '0;
      vga_x    <= XRst;
      vga_y    <= YRst;
      moved    <= 1'b0;
    end else begin
      sx       <= positionX;
      sy       <= positionY;
      tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
      moved    <= 1'b0;
      if (tick && enable) begin
        vga_x <= next_x;
        vga_y <= next_y;
        moved <= (next_x != vga_x) || (next_y != vga_y);
      end
    end
  end

endmodule

// File: tb/tb_cursor_tracker.sv
// Bench for cursor_tracker: per-edge expectations from a plain integer model are queued
// and a negedge monitor compares them against the DUT outputs.
module tb_cursor_tracker;

  localparam int TickDiv = 4;
  localparam int HRes    = 640;
  localparam int VRes    = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  positionX = '0;
  logic [7:0]  positionY = '0;
  logic        enable = 1'b1;
  logic [10:0] vga_x, vga_y;
  logic        moved;

  cursor_tracker #(
    .H_RES   (HRes),
    .V_RES   (VRes),
    .TICK_DIV(TickDiv)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .positionX(positionX),
    .positionY(positionY),
    .enable   (enable),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .moved    (moved)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit mv;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_x = HRes / 2;
  int m_y = VRes / 2;
  int m_sx = 0;
  int m_sy = 0;
  int m_cnt = 0;

  function automatic int speed(input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m <= 48) return 0;
    if (m >= 96) return 4;
    return 1;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One clock edge of the reference model, using the inputs driven before the edge.
  task automatic model_edge();
    exp_t e;
    int nx, ny;
    bit tick;
    e.mv = 1'b0;
    if (reset) begin
      m_x = HRes / 2; m_y = VRes / 2; m_sx = 0; m_sy = 0; m_cnt = 0;
    end else begin
      tick = (m_cnt == TickDiv - 1);
      if (tick && enable) begin
        nx = clamp(m_x + ((m_sx < 0) ? -speed(m_sx) : speed(m_sx)), HRes - 1);
        ny = clamp(m_y + ((m_sy < 0) ? speed(m_sy) : -speed(m_sy)), VRes - 1);
        e.mv = (nx != m_x) || (ny != m_y);
        m_x = nx; m_y = ny;
      end
      m_cnt = tick ? 0 : m_cnt + 1;
      m_sx = int'($signed(positionX));
      m_sy = int'($signed(positionY));
    end
    e.x = m_x;
    e.y = m_y;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [7:0] px, input logic [7:0] py, input logic en,
                     input logic rst);
    positionX = px;
    positionY = py;
    enable    = en;
    reset     = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input logic [7:0] px, input logic [7:0] py, input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(px, py, en, 1'b0);
  endtask

  // Direct comparison against values worked out by hand from the cursor rules.
  task automatic check_pos(input string name, input int ex, input int ey);
    checks++;
    if (vga_x !== 11'(ex) || vga_y !== 11'(ey)) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d, expected x=%0d y=%0d", name, vga_x, vga_y, ex, ey);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (vga_x !== 11'(e.x) || vga_y !== 11'(e.y) || moved !== e.mv) begin
        failures++;
        $display("FAIL edge_compare t=%0t: got x=%0d y=%0d moved=%b, expected x=%0d y=%0d moved=%b",
                 $time, vga_x, vga_y, moved, e.x, e.y, e.mv);
      end
    end
  end

  logic [7:0] picks [11];

  initial begin
    picks = '{8'd48, 8'd49, 8'd95, 8'd96, 8'hD0, 8'hCF, 8'hA0, 8'hA1, 8'h80, 8'h7F, 8'h00};

    // Reset hold with full deflection, then first update on the fourth edge
    for (int i = 0; i < 3; i++) cyc(8'h7F, 8'h00, 1'b1, 1'b1);
    check_pos("reset_hold", 320, 240);
    run(8'h7F, 8'h00, 1'b1, 3);
    check_pos("before_first_tick", 320, 240);
    run(8'h7F, 8'h00, 1'b1, 1);
    check_pos("first_tick", 324, 240);

    // Deadzone boundaries in both signs, then just outside it
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h30, 8'h00, 1'b1, 20);
    run(8'hD0, 8'h00, 1'b1, 20);
    check_pos("deadzone", 320, 240);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h31, 8'h00, 1'b1, 12);
    check_pos("slow_right", 323, 240);

    // Fast tier via -96 on X and -128 on Y
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'hA0, 8'h80, 1'b1, 12);
    check_pos("fast_tiers", 308, 252);

    // Saturation at right and top edges
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h7F, 8'h7F, 1'b1, 800);
    check_pos("clamp_edges", 639, 0);

    // Approach the right edge so a fast step would overshoot
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h7F, 8'h00, 1'b1, 79 * 4);
    check_pos("reach_636", 636, 240);
    run(8'h31, 8'h00, 1'b1, 4);
    check_pos("reach_637", 637, 240);
    run(8'h7F, 8'h00, 1'b1, 4);
    check_pos("fast_near_edge", 639, 240);

    // Enable low holds the cursor; reset on a tick edge wins
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h7F, 8'h7F, 1'b0, 40);
    check_pos("enable_low", 320, 240);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    run(8'h7F, 8'h80, 1'b1, 3);
    cyc(8'h7F, 8'h80, 1'b1, 1'b1);
    check_pos("reset_on_tick", 320, 240);

    // Randomised mix biased toward the tier boundaries
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] px, py;
      px = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 10)] : 8'($urandom);
      py = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 10)] : 8'($urandom);
      cyc(px, py, ($urandom_range(0, 7) != 0), ($urandom_range(0, 299) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cursor_tracker.md
# cursor_tracker

Parametrised joystick-to-cursor integrator: converts two signed 8-bit joystick deflections into a clamped VGA cursor position. It supports a configurable deadzone, two speed tiers, a programmable update rate, and a change strobe. It sits between the joystick sampler and the drawing/VGA pixel logic, and replaces the fixed one-pixel-per-clock translator. Cursor movement is bounded to the visible area and does not wrap.

## Interface
Parameters:
- H_RES, 640, visible width in pixels; vga_x range 0..H_RES-1
- V_RES, 480, visible height in pixels; vga_y range 0..V_RES-1
- COORD_W, 11, width of vga_x/vga_y; must satisfy 2^COORD_W > max(H_RES, V_RES)+FAST_STEP
- DEADZONE, 48, deflection magnitude <= DEADZONE gives no movement
- FAST_THRESH, 96, magnitude >= FAST_THRESH uses FAST_STEP, else SLOW_STEP
- SLOW_STEP, 1, pixels per tick, slow tier
- FAST_STEP, 4, pixels per tick, fast tier
- TICK_DIV, 416667, clocks per movement tick (120 Hz at 50 MHz); >= 2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- positionX  in  8  X deflection, two's complement; negative = left
- positionY  in  8  Y deflection, two's complement; negative = down on screen (vga_y increases)
- enable  in  1  when low, ticks are ignored and the cursor holds
- vga_x  out  COORD_W  cursor column
- vga_y  out  COORD_W  cursor row
- moved  out  1  one-cycle pulse: coordinates changed at this edge

## Operation
- Input stage: positionX/positionY registered every clock into sx/sy. All movement decisions use sx/sy.
- Magnitude: |s| computed in 8-bit unsigned arithmetic; -128 → 128 and is treated as fast.
- Step per axis: 0 if |s| <= DEADZONE; SLOW_STEP if DEADZONE < |s| < FAST_THRESH; FAST_STEP if |s| >= FAST_THRESH.
- Direction:
  - X: s<0 → subtract step; s>0 → add step.
  - Y: s<0 → add step; s>0 → subtract step.
- Tick counter: counts 0..TICK_DIV-1 and wraps to 0. tick=1 in the cycle the count equals TICK_DIV-1. The counter runs regardless of enable.
- On a clock edge with tick && enable, each axis updates independently:
  - Subtract: new = (cur < step) ? 0 : cur-step.
  - Add: new = (cur+step > MAX) ? MAX : cur+step, with MAX = H_RES-1 or V_RES-1.
  - Compare in COORD_W+1 bits; no wrap-around is permitted.
- moved is registered at the same edge as the coordinates. It is 1 iff new vga_x != old or new vga_y != old, so it is 0 when clamped at an edge and pushing further. It is 0 on all non-tick edges.
- Reset values: vga_x = H_RES/2, vga_y = V_RES/2 (integer division), moved = 0, tick counter = 0, sx = sy = 0.
- Reset asserted mid-operation overrides any tick in the same cycle.

## Timing
- Input-to-use latency: 1 clock (input register).
- A deflection present on positionX at edge k affects the coordinate at the first tick edge >= k+1.
- After reset deasserts, the first tick edge is the TICK_DIV-th clock edge.
- Coordinates change at most once per TICK_DIV clocks, by at most FAST_STEP per axis.
- moved is high for exactly one clock and is aligned with the new coordinate values.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: TICK_DIV=4, H_RES=640, V_RES=480, defaults otherwise.
- Reset hold: assert reset for 3 clocks with positionX=0x7F → vga_x=320, vga_y=240, moved=0 throughout; release reset → first update occurs 4 edges later.
- Deadzone and sign: positionX=0x30 (48), then 0xD0 (-48), for 5 ticks each → vga_x stays 320, moved never pulses. Then positionX=0x31 → vga_x = 321, 322, … on successive ticks, with moved pulsing once per tick.
- Speed tiers and axis senses: positionX=0xA0 (-96), positionY=0x80 (-128) for 3 ticks → vga_x = 308, vga_y = 252; moved pulses 3 times, 4 clocks apart.
- Clamp at edges: start at reset, positionX=0x7F, positionY=0x7F for 200 ticks → vga_x saturates at 639, vga_y at 0, never wraps. moved=0 on every tick after both axes saturate.
- Fast-step near edge: drive vga_x to 637 (slow steps from 636), then positionX=0x7F → next tick gives 639, not 641 or a wrapped value.
- Enable and mid-run reset: enable=0 with positionX=0x7F for 10 ticks → no change, moved=0. Assert reset on a tick edge with enable=1 → outputs return to 320/240 and moved=0 in that cycle.
